// File: rtl/pipe_alu.sv
// Execute-stage 16-bit ALU: combinational result/address plus registered {V,N,Z,C} flags.
// Optional macro ALU_MUL_EN enables the low-16-bit unsigned multiply on alu_op 14.
module pipe_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBB = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_CMP  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_MOV  = 4'd15;

  // Packs {V,N,Z,C}; Z and N always derive from the result itself.
  function automatic logic [3:0] pack_flags(input logic v, input logic [15:0] res, input logic c);
    pack_flags = {v, res[15], (res == 16'h0000), c};
  endfunction

  // Signed overflow of a+b: same operand signs, different result sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    add_ovf = (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  logic [3:0]  flags_r;
  logic [3:0]  sh_s;
  logic [15:0] add_b_s;
  logic        add_cin_s;
  logic [16:0] sum_s;
  logic [16:0] shl_s;
  logic [16:0] shr_s;
  logic [16:0] sar_s;
  logic [15:0] rol_s;
  logic [15:0] ror_s;
  logic [15:0] addr_s;
  logic [15:0] alu_res_s;
  logic        alu_c_s;
  logic        alu_v_s;
  logic [3:0]  next_flags_s;
  logic        sh_nz_s;

  assign sh_s    = rhs[3:0];
  assign sh_nz_s = (sh_s != 4'd0);
  assign addr_s  = lhs + rhs;

  // Shifters carry an extra guard bit so the last bit shifted out falls into it.
  assign shl_s = {1'b0, lhs} << sh_s;
  assign shr_s = {lhs, 1'b0} >> sh_s;
  assign sar_s = $signed({lhs, 1'b0}) >>> sh_s;
  assign rol_s = (lhs << sh_s) | (lhs >> (5'd16 - {1'b0, sh_s}));
  assign ror_s = (lhs >> sh_s) | (lhs << (5'd16 - {1'b0, sh_s}));

`ifdef ALU_MUL_EN
  logic [15:0] mul_s;
  assign mul_s = lhs * rhs;
`endif

  // Shared adder operand select: subtraction is lhs + ~rhs + cin.
  always_comb begin
    add_b_s   = rhs;
    add_cin_s = 1'b0;
    case (alu_op)
      OP_ADD:  begin add_b_s = rhs;  add_cin_s = 1'b0;       end
      OP_ADDC: begin add_b_s = rhs;  add_cin_s = flags_r[0]; end
      OP_SUB:  begin add_b_s = ~rhs; add_cin_s = 1'b1;       end
      OP_SUBB: begin add_b_s = ~rhs; add_cin_s = flags_r[0]; end
      OP_CMP:  begin add_b_s = ~rhs; add_cin_s = 1'b1;       end
      default: begin add_b_s = rhs;  add_cin_s = 1'b0;       end
    endcase
  end

  assign sum_s = {1'b0, lhs} + {1'b0, add_b_s} + {16'd0, add_cin_s};

  // ALU-class result and the carry/overflow it produces.
  always_comb begin
    alu_res_s = 16'h0000;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (alu_op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBB, OP_CMP: begin
        alu_res_s = sum_s[15:0];
        alu_c_s   = sum_s[16];
        alu_v_s   = add_ovf(lhs[15], add_b_s[15], sum_s[15]);
      end
      OP_AND: alu_res_s = lhs & rhs;
      OP_OR:  alu_res_s = lhs | rhs;
      OP_XOR: alu_res_s = lhs ^ rhs;
      OP_NOT: alu_res_s = ~rhs;
      OP_SHL: begin alu_res_s = shl_s[15:0]; alu_c_s = shl_s[16]; end
      OP_SHR: begin alu_res_s = shr_s[16:1]; alu_c_s = shr_s[0];  end
      OP_SAR: begin alu_res_s = sar_s[16:1]; alu_c_s = sar_s[0];  end
      // Rotates: the last bit out lands at the opposite end of the result.
      OP_ROL: begin alu_res_s = rol_s; alu_c_s = sh_nz_s & rol_s[0];  end
      OP_ROR: begin alu_res_s = ror_s; alu_c_s = sh_nz_s & ror_s[15]; end
`ifdef ALU_MUL_EN
      OP_MUL: alu_res_s = mul_s;
`else
      OP_MUL: alu_res_s = 16'h0000;
`endif
      OP_MOV: alu_res_s = rhs;
      default: begin
        alu_res_s = 16'h0000;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
      end
    endcase
  end

  assign next_flags_s = pack_flags(alu_v_s, alu_res_s, alu_c_s);

  // Opcode-level result mux: ALU, pass-through or address add.
  always_comb begin
    result = 16'h0000;
    case (opcode)
      3'b000, 3'b001:         result = alu_res_s;
      3'b010, 3'b011, 3'b111: result = lhs;
      3'b100, 3'b101, 3'b110: result = addr_s;
      default:                result = 16'h0000;
    endcase
  end

  // Flag register: only ALU-class opcodes write it, reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= 4'b0000;
    end else if (opcode[2:1] == 2'b00) begin
      flags_r <= next_flags_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign flags = flags_r;

endmodule

// File: tb/tb_pipe_alu.sv
// Directed scoreboard bench for pipe_alu: result checked combinationally, flags one edge later.
module tb_pipe_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  opcode;
  logic [3:0]  alu_op;
  logic [15:0] lhs;
  logic [15:0] rhs;
  logic [15:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb_q[$];

  pipe_alu #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .alu_op (alu_op),
    .lhs    (lhs),
    .rhs    (rhs),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Drive one instruction at the negedge, check result, then flags after the edge.
  task automatic step(input string tag, input logic r, input logic [2:0] op,
                      input logic [3:0] aop, input logic [15:0] l, input logic [15:0] rr,
                      input logic [15:0] exp_res, input logic [3:0] exp_flg);
    exp_t e;
    exp_t cur;
    rst    = r;
    opcode = op;
    alu_op = aop;
    lhs    = l;
    rhs    = rr;
    e.tag = tag;
    e.res = exp_res;
    e.flg = exp_flg;
    sb_q.push_back(e);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      cur = sb_q.pop_front();
      assert (result === cur.res) else begin
        errors++;
        $error("FAIL %s result: got %h expected %h", cur.tag, result, cur.res);
      end
      @(posedge clk);
      #1;
      checks++;
      assert (flags === cur.flg) else begin
        errors++;
        $error("FAIL %s flags: got %b expected %b", cur.tag, flags, cur.flg);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; opcode = 3'b110; alu_op = 4'd0; lhs = 16'h0000; rhs = 16'h0000;
    @(negedge clk);
    // tag, rst, opcode, alu_op, lhs, rhs, expected result, expected {V,N,Z,C}
    step("reset",      1'b1, 3'b110, 4'd0,  16'h0005, 16'h0003, 16'h0008, 4'b0000);
    step("bubble110",  1'b0, 3'b110, 4'd0,  16'h0005, 16'h0003, 16'h0008, 4'b0000);
    step("add_ovf",    1'b0, 3'b000, 4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1100);
    step("sub_eq",     1'b0, 3'b001, 4'd2,  16'h1234, 16'h1234, 16'h0000, 4'b0011);
    step("sub_borrow", 1'b0, 3'b001, 4'd2,  16'h0001, 16'h0002, 16'hFFFF, 4'b0100);
    step("add_carry",  1'b0, 3'b000, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0011);
    step("addc",       1'b0, 3'b000, 4'd1,  16'h0000, 16'h0000, 16'h0001, 4'b0000);
    step("shl",        1'b0, 3'b000, 4'd8,  16'h8001, 16'h0001, 16'h0002, 4'b0001);
    step("sar15",      1'b0, 3'b000, 4'd10, 16'h8000, 16'h000F, 16'hFFFF, 4'b0100);
    step("ror1",       1'b0, 3'b000, 4'd12, 16'h0001, 16'h0001, 16'h8000, 4'b0101);
    step("sub_setz",   1'b0, 3'b001, 4'd2,  16'h0040, 16'h0040, 16'h0000, 4'b0011);
    step("hold011",    1'b0, 3'b011, 4'd2,  16'h0040, 16'h0002, 16'h0040, 4'b0011);
    step("hold100",    1'b0, 3'b100, 4'd2,  16'h0040, 16'h0002, 16'h0042, 4'b0011);
    step("hold111",    1'b0, 3'b111, 4'd2,  16'h0040, 16'h0002, 16'h0040, 4'b0011);
    step("mul",        1'b0, 3'b000, 4'd14, 16'h0100, 16'h0100, 16'h0000, 4'b0010);
    step("subb_c0",    1'b0, 3'b001, 4'd3,  16'h0005, 16'h0003, 16'h0001, 4'b0001);
    step("subb_c1",    1'b0, 3'b001, 4'd3,  16'h8000, 16'h0001, 16'h7FFF, 4'b1001);
    step("xor",        1'b0, 3'b000, 4'd6,  16'hA5A5, 16'hFFFF, 16'h5A5A, 4'b0000);
    step("rol1",       1'b0, 3'b000, 4'd11, 16'h8001, 16'h0001, 16'h0003, 4'b0001);
    step("shr0",       1'b0, 3'b000, 4'd9,  16'h0003, 16'h0000, 16'h0003, 4'b0000);
    step("cmp_lt",     1'b0, 3'b001, 4'd13, 16'h0002, 16'h0005, 16'hFFFD, 4'b0100);
    step("and",        1'b0, 3'b000, 4'd4,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
    step("not",        1'b0, 3'b001, 4'd7,  16'h1234, 16'h00FF, 16'hFF00, 4'b0100);
    step("mov0",       1'b0, 3'b000, 4'd15, 16'h1234, 16'h0000, 16'h0000, 4'b0010);
    step("pass010",    1'b0, 3'b010, 4'd0,  16'h1234, 16'h5678, 16'h1234, 4'b0010);
    step("rst_prio",   1'b1, 3'b000, 4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0000);
    step("post_rst",   1'b0, 3'b101, 4'd0,  16'hFFF0, 16'h0020, 16'h0010, 4'b0000);
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
Name: pipe_alu

Overview:
- 16-bit integer ALU in the execute stage of the pipelined CPU.
- Produces a combinational result, which serves as the ALU result, the load/store address and the jump target.
- Holds a 4-bit flag register {V,N,Z,C} that later conditional branches evaluate.
- Flags are written only by ALU-class instructions, so a branch tests the flags of the most recent ALU op.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.

Ports:
- clk  input  1  clock; flags update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  3  instruction class.
- alu_op  input  4  operation select, used when opcode is 000 or 001.
- lhs  input  16  left operand.
- rhs  input  16  right operand (register value or immediate, muxed upstream).
- result  output  16  combinational result/address.
- flags  output  4  registered flags: [0]=C carry, [1]=Z zero, [2]=N negative, [3]=V signed overflow.

Behaviour:
- result is purely combinational from opcode, alu_op, lhs, rhs and the current flags (C is used by ADDC/SUBB). No reset value and no latency.
- Opcode decode:
  - 000 and 001: ALU op selected by alu_op.
  - 010: result=lhs.
  - 011: result=lhs (immediate pass-through).
  - 100 and 101: result=lhs+rhs (load/store address, mod 2^16).
  - 110: result=lhs+rhs; unused by branches.
  - 111: result=lhs (register jump target).
- alu_op encoding, all arithmetic mod 2^16:
  - 0 ADD: lhs+rhs.
  - 1 ADDC: lhs+rhs+C.
  - 2 SUB: lhs+~rhs+1.
  - 3 SUBB: lhs+~rhs+C.
  - 4 AND; 5 OR; 6 XOR.
  - 7 NOT: ~rhs.
  - 8 SHL: lhs<<rhs[3:0].
  - 9 SHR: logical lhs>>rhs[3:0].
  - 10 SAR: arithmetic shift right by rhs[3:0].
  - 11 ROL; 12 ROR: rotate by rhs[3:0].
  - 13 CMP: same result and flags as SUB.
  - 14 MUL: see Optional Feature.
  - 15 MOV: result=rhs.
- Next-flag rules:
  - Z = (result==0).
  - N = result[15].
  - ADD/ADDC: C = carry out of bit 15; V = operands share a sign and result sign differs.
  - SUB/SUBB/CMP: C = carry out of lhs+~rhs+cin, so C=1 means no borrow (lhs>=rhs unsigned); V = operand signs differ and result sign differs from lhs.
  - SHL/ROL: C = last bit shifted out of the MSB side. SHR/SAR/ROR: C = last bit shifted out of the LSB side. Shift/rotate amount 0 gives C=0. V=0.
  - Logic ops, NOT, MOV, MUL: C=0, V=0.
- Flag register update, at the rising edge:
  - rst=1: flags<=4'b0000. This has priority over everything else.
  - Else if opcode is 000 or 001: flags<=next flags.
  - Else: flags hold.
- Bubbles must be presented with an opcode other than 000/001. The upstream stage guarantees this.
- flags are visible one cycle after the ALU op. A branch in the immediately following cycle therefore sees the new flags.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: alu_op 14 gives result = low 16 bits of the unsigned lhs*rhs. Z and N are set from the result; C=0, V=0.
- Undefined: alu_op 14 gives result = 16'h0000 and flags update as Z=1, N=0, C=0, V=0. No multiplier is synthesized.

Test Plan:
- Reset: rst=1 for one edge -> flags=0000. Then opcode=110 with lhs=5, rhs=3 -> flags stay 0000 and result=8.
- ADD overflow: opcode=000, alu_op=0, lhs=7FFF, rhs=0001 -> result=8000 combinationally; next edge flags V=1, N=1, Z=0, C=0 (1100).
- SUB equal: opcode=001, alu_op=2, lhs=rhs=1234 -> result=0000; flags C=1, Z=1, N=0, V=0 (0011). Then lhs=0001, rhs=0002 -> result=FFFF; flags C=0, N=1 (0100).
- Carry chain: ADD FFFF+0001 -> result 0000, flags C=1, Z=1. Then ADDC 0000+0000 -> result=0001, flags=0000.
- Shifts: SHL lhs=8001, rhs=1 -> result=0002, C=1. SAR lhs=8000, rhs=15 -> FFFF, N=1. ROR lhs=0001, rhs=1 -> 8000, C=1.
- Non-ALU opcodes hold flags: set Z=1 via SUB, then opcodes 011/100/111 with lhs=0040, rhs=0002 -> results 0040, 0042, 0040 respectively; flags unchanged. With ALU_MUL_EN, MUL 0100*0100 -> result=0000, Z=1.
